// File: rtl/colour_bbox_overlay.sv
// Avalon-ST video stage: tracks the bounding box of pixels inside a fixed RGB window per frame.
// Optional perimeter overlay of the previous frame's box is enabled by defining BBOX_OVERLAY_EN.
module colour_bbox_overlay #(
    parameter int          IMAGE_W    = 640,
    parameter int          IMAGE_H    = 480,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  G_MAX      = 8'd80,
    parameter logic [7:0]  B_MAX      = 8'd80,
    parameter logic [23:0] BOX_COLOUR = 24'h00FF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    output logic [10:0] bbox_x_min,
    output logic [10:0] bbox_x_max,
    output logic [10:0] bbox_y_min,
    output logic [10:0] bbox_y_max,
    output logic        bbox_found,
    output logic        bbox_update
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_VIDEO = 2'd1;
    localparam logic [1:0]  ST_OTHER = 2'd2;
    localparam logic [10:0] X_LAST   = 11'(IMAGE_W - 1);
    localparam logic [10:0] Y_END    = 11'(IMAGE_H);

    logic [1:0]  state;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [10:0] run_x_min;
    logic [10:0] run_x_max;
    logic [10:0] run_y_min;
    logic [10:0] run_y_max;
    logic        hit;

    logic        accept;
    logic        video_sop;
    logic        pix_beat;
    logic        match;
    logic        frame_end;
    logic [10:0] nxt_x_min;
    logic [10:0] nxt_x_max;
    logic [10:0] nxt_y_min;
    logic [10:0] nxt_y_max;
    logic [23:0] out_data;

    assign sink_ready = source_ready | ~source_valid;
    assign accept     = sink_valid & sink_ready;
    assign video_sop  = accept & sink_sop & (sink_data[3:0] == 4'h0);
    assign pix_beat   = accept & ~sink_sop & (state == ST_VIDEO) & (y_cnt < Y_END);
    assign match      = pix_beat & (sink_data[23:16] >= R_MIN)
                        & (sink_data[15:8] <= G_MAX) & (sink_data[7:0] <= B_MAX);
    assign frame_end  = accept & ~sink_sop & sink_eop & (state == ST_VIDEO);

    // Running box including the current beat, so a match on the eop pixel is latched too.
    always_comb begin
        nxt_x_min = run_x_min;
        nxt_x_max = run_x_max;
        nxt_y_min = run_y_min;
        nxt_y_max = run_y_max;
        if (match) begin
            if (!hit) begin
                nxt_x_min = x_cnt;
                nxt_x_max = x_cnt;
                nxt_y_min = y_cnt;
                nxt_y_max = y_cnt;
            end else begin
                if (x_cnt < run_x_min) nxt_x_min = x_cnt;
                if (x_cnt > run_x_max) nxt_x_max = x_cnt;
                if (y_cnt < run_y_min) nxt_y_min = y_cnt;
                if (y_cnt > run_y_max) nxt_y_max = y_cnt;
            end
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic on_col;
    logic on_row;

    assign on_col   = ((x_cnt == bbox_x_min) | (x_cnt == bbox_x_max))
                      & (y_cnt >= bbox_y_min) & (y_cnt <= bbox_y_max);
    assign on_row   = ((y_cnt == bbox_y_min) | (y_cnt == bbox_y_max))
                      & (x_cnt >= bbox_x_min) & (x_cnt <= bbox_x_max);
    assign out_data = (pix_beat & bbox_found & (on_col | on_row)) ? BOX_COLOUR : sink_data;
`else
    assign out_data = sink_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            source_valid <= 1'b0;
            source_data  <= 24'h0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else begin
            if (sink_ready) begin
                source_valid <= sink_valid;
            end
            if (accept) begin
                source_data <= out_data;
                source_sop  <= sink_sop;
                source_eop  <= sink_eop;
            end
        end
    end

    // A sop with sop and eop together is a header-only packet and leaves the decoder idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            x_cnt     <= 11'd0;
            y_cnt     <= 11'd0;
            hit       <= 1'b0;
            run_x_min <= 11'd0;
            run_x_max <= 11'd0;
            run_y_min <= 11'd0;
            run_y_max <= 11'd0;
        end else if (accept) begin
            if (sink_sop) begin
                if (sink_eop) begin
                    state <= ST_IDLE;
                end else if (sink_data[3:0] == 4'h0) begin
                    state <= ST_VIDEO;
                end else begin
                    state <= ST_OTHER;
                end
                if (video_sop) begin
                    x_cnt     <= 11'd0;
                    y_cnt     <= 11'd0;
                    hit       <= 1'b0;
                    run_x_min <= 11'd0;
                    run_x_max <= 11'd0;
                    run_y_min <= 11'd0;
                    run_y_max <= 11'd0;
                end
            end else begin
                if (sink_eop) begin
                    state <= ST_IDLE;
                end
                if (pix_beat) begin
                    if (x_cnt == X_LAST) begin
                        x_cnt <= 11'd0;
                        y_cnt <= y_cnt + 11'd1;
                    end else begin
                        x_cnt <= x_cnt + 11'd1;
                    end
                end
                if (match) begin
                    hit       <= 1'b1;
                    run_x_min <= nxt_x_min;
                    run_x_max <= nxt_x_max;
                    run_y_min <= nxt_y_min;
                    run_y_max <= nxt_y_max;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bbox_x_min  <= 11'd0;
            bbox_x_max  <= 11'd0;
            bbox_y_min  <= 11'd0;
            bbox_y_max  <= 11'd0;
            bbox_found  <= 1'b0;
            bbox_update <= 1'b0;
        end else begin
            bbox_update <= frame_end;
            if (frame_end) begin
                if (hit | match) begin
                    bbox_x_min <= nxt_x_min;
                    bbox_x_max <= nxt_x_max;
                    bbox_y_min <= nxt_y_min;
                    bbox_y_max <= nxt_y_max;
                    bbox_found <= 1'b1;
                end else begin
                    bbox_found <= 1'b0;
                end
            end
        end
    end

endmodule
